pipe_mips32: RTL and testbench

- Five-stage in-order MIPS32-subset CPU: IF, ID, EX, MEM, WB.
- Unified word-addressed instruction/data memory and 32x32 register file, both held internally.
- Top-level compute block of the processor sandbox; benches preload and inspect state hierarchically.
- The two-phase clk1/clk2 scheme is replaced by one rising-edge clock. Every pipeline register updates on posedge clk.

---
 rtl/mips32_pkg.sv | 95 +++++++++
 rtl/mips32_alu.sv | 41 ++++
 rtl/pipe_mips32.sv | 226 ++++++++++++++++++++++
 tb/tb_pipe_mips32.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared types for the pipe_mips32 core: opcodes, instruction
// classes, instruction field positions and the pipeline register bundles.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } cls_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    cls_t        cls;
    logic [5:0]  op;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        we;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    cls_t        cls;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        we;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    cls_t        cls;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic [4:0]  dest;
    logic        we;
  } mem_wb_t;

  function automatic cls_t decode_cls(input logic [5:0] op);
    cls_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_SLT, OP_MUL:    c = RR_ALU;
      OP_ADDI, OP_SUBI,
      OP_SLTI:                  c = RM_ALU;
      OP_LW:                    c = LOAD;
      OP_SW:                    c = STORE;
      OP_BNEQZ, OP_BEQZ:        c = BRANCH;
      OP_HLT:                   c = HALT;
      default:                  c = NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for pipe_mips32.
// Ports: cls/op select the operation, a/b operands, y result.
import mips32_pkg::*;

module mips32_alu (
  input  cls_t        cls,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    unique case (cls)
      RR_ALU: begin
        case (op)
          OP_ADD:  y = a + b;
          OP_SUB:  y = a - b;
          OP_AND:  y = a & b;
          OP_OR:   y = a | b;
          OP_SLT:  y = {31'd0, $signed(a) < $signed(b)};
          // low 32 bits are identical for signed and unsigned products
          OP_MUL:  y = a * b;
          default: y = '0;
        endcase
      end
      RM_ALU: begin
        case (op)
          OP_ADDI: y = a + b;
          OP_SUBI: y = a - b;
          OP_SLTI: y = {31'd0, $signed(a) < $signed(b)};
          default: y = '0;
        endcase
      end
      LOAD, STORE: y = a + b;
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with internal Reg/Mem arrays.
// Ports: clk, rst_n (async low), halted (HLT retired), pc (fetch PC).
import mips32_pkg::*;

module pipe_mips32 #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        stop;

  if_id_t  ifid;
  id_ex_t  idex;
  ex_mem_t exmem;
  mem_wb_t memwb;

  logic [5:0]  id_op;
  cls_t        id_cls;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_dest;
  logic [31:0] id_imm;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic        id_we;
  logic        use_rs;
  logic        use_rt;
  logic        stall;
  logic        halt_id;
  logic        fetch_en;

  logic        ex_valid;
  logic        taken;
  logic [31:0] fa;
  logic [31:0] fb;
  logic [31:0] alu_b;
  logic [31:0] ex_y;
  logic [31:0] target;

  logic [AW-1:0] mem_addr;
  logic [31:0]   lmd;
  logic          mem_we;
  logic [31:0]   wb_data;
  logic          wb_we;

  assign halted = HALTED;
  assign pc     = PC;

  assign id_op   = ifid.ir[OP_HI:OP_LO];
  assign id_cls  = decode_cls(id_op);
  assign id_rs   = ifid.ir[RS_HI:RS_LO];
  assign id_rt   = ifid.ir[RT_HI:RT_LO];
  assign id_rd   = ifid.ir[RD_HI:RD_LO];
  assign id_imm  = {{16{ifid.ir[IMM_HI]}},
                    ifid.ir[IMM_HI:IMM_LO]};
  assign id_dest = (id_cls == RR_ALU) ? id_rd : id_rt;
  assign id_we   = (id_cls == RR_ALU) ||
                   (id_cls == RM_ALU) ||
                   (id_cls == LOAD);
  assign use_rs  = id_we || (id_cls == STORE) ||
                   (id_cls == BRANCH);
  assign use_rt  = (id_cls == RR_ALU) ||
                   (id_cls == STORE);

  assign wb_data = (memwb.cls == LOAD) ? memwb.lmd
                                       : memwb.alu;
  assign wb_we   = memwb.valid && memwb.we &&
                   (memwb.dest != 5'd0) && !HALTED;

  // Register read with same-cycle write-through from WB.
  always_comb begin
    id_a = Reg[id_rs];
    if (id_rs == 5'd0)
      id_a = '0;
    else if (wb_we && memwb.dest == id_rs)
      id_a = wb_data;
    id_b = Reg[id_rt];
    if (id_rt == 5'd0)
      id_b = '0;
    else if (wb_we && memwb.dest == id_rt)
      id_b = wb_data;
  end

  // The wrong-path instruction that slipped into ID/EX on the
  // redirect edge is killed here, one cycle later.
  assign ex_valid = idex.valid && !TAKEN_BRANCH;

  assign stall = ifid.valid && ex_valid &&
                 (idex.cls == LOAD) &&
                 (idex.dest != 5'd0) &&
                 ((use_rs && id_rs == idex.dest) ||
                  (use_rt && id_rt == idex.dest));

  assign halt_id  = ifid.valid && (id_cls == HALT);
  assign fetch_en = !stop && !halt_id && !HALTED;

  // A load in EX/MEM never matches here: the interlock keeps
  // its consumer in ID until the load reaches WB.
  always_comb begin
    fa = idex.a;
    if (idex.rs != 5'd0) begin
      if (exmem.valid && exmem.we &&
          exmem.cls != LOAD &&
          exmem.dest == idex.rs)
        fa = exmem.alu;
      else if (wb_we && memwb.dest == idex.rs)
        fa = wb_data;
    end
    fb = idex.b;
    if (idex.rt != 5'd0) begin
      if (exmem.valid && exmem.we &&
          exmem.cls != LOAD &&
          exmem.dest == idex.rt)
        fb = exmem.alu;
      else if (wb_we && memwb.dest == idex.rt)
        fb = wb_data;
    end
  end

  assign alu_b = (idex.cls == RR_ALU) ? fb : idex.imm;

  mips32_alu u_alu (
    .cls (idex.cls),
    .op  (idex.op),
    .a   (fa),
    .b   (alu_b),
    .y   (ex_y)
  );

  assign taken  = ex_valid && (idex.cls == BRANCH) &&
                  ((idex.op == OP_BEQZ) ? (fa == '0)
                                        : (fa != '0));
  assign target = idex.npc + idex.imm;

  assign mem_addr = exmem.alu[AW-1:0];
  assign lmd      = Mem[mem_addr];
  assign mem_we   = exmem.valid && (exmem.cls == STORE) &&
                    !HALTED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= RESET_PC;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      stop         <= 1'b0;
      ifid         <= '0;
      idex         <= '0;
      exmem        <= '0;
      memwb        <= '0;
    end else begin
      TAKEN_BRANCH <= taken;
      if (memwb.valid && memwb.cls == HALT)
        HALTED <= 1'b1;
      if (halt_id && !taken)
        stop <= 1'b1;

      if (HALTED) begin
        ifid.valid <= 1'b0;
      end else if (taken) begin
        PC         <= target;
        ifid.valid <= 1'b0;
      end else if (stall) begin
        ifid <= ifid;
      end else if (fetch_en) begin
        PC         <= PC + 32'd1;
        ifid.valid <= 1'b1;
        ifid.ir    <= Mem[PC[AW-1:0]];
        ifid.npc   <= PC + 32'd1;
      end else begin
        ifid.valid <= 1'b0;
      end

      if (stall) begin
        idex.valid <= 1'b0;
      end else begin
        idex.valid <= ifid.valid;
        idex.cls   <= id_cls;
        idex.op    <= id_op;
        idex.npc   <= ifid.npc;
        idex.a     <= id_a;
        idex.b     <= id_b;
        idex.imm   <= id_imm;
        idex.rs    <= id_rs;
        idex.rt    <= id_rt;
        idex.dest  <= id_dest;
        idex.we    <= id_we;
      end

      exmem.valid <= ex_valid;
      exmem.cls   <= idex.cls;
      exmem.alu   <= ex_y;
      exmem.b     <= fb;
      exmem.dest  <= idex.dest;
      exmem.we    <= idex.we;

      memwb.valid <= exmem.valid;
      memwb.cls   <= exmem.cls;
      memwb.alu   <= exmem.alu;
      memwb.lmd   <= lmd;
      memwb.dest  <= exmem.dest;
      memwb.we    <= exmem.we;
    end
  end

  // Architectural state is never reset; rst_n only blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      Mem[mem_addr] <= exmem.b;
    if (rst_n && wb_we)
      Reg[memwb.dest] <= wb_data;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed bench for pipe_mips32.
// Preloads Reg/Mem during reset and checks results hierarchically.
module tb_pipe_mips32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halted;
  logic [31:0] pc;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [0:15];
  int          plen;

  pipe_mips32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  task automatic load_prog();
    for (int i = 0; i < 1024; i++)
      dut.Mem[i] = 32'd0;
    for (int i = 0; i < plen; i++)
      dut.Mem[i] = prog[i];
    for (int k = 0; k < 32; k++)
      dut.Reg[k] = 32'(k);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int max, output int n);
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic load_fact();
    plen = 11;
    prog[0]  = 32'h280a00c8;
    prog[1]  = 32'h28020001;
    prog[2]  = 32'h21430000;
    prog[3]  = 32'h14431000;
    prog[4]  = 32'h2c630001;
    prog[5]  = 32'h3460fffd;
    prog[6]  = 32'h38000002;
    prog[7]  = 32'h28090001;
    prog[8]  = 32'h28090001;
    prog[9]  = 32'h2542fffe;
    prog[10] = 32'hfc000000;
    load_prog();
    dut.Mem[200] = 32'd7;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_pc: got %0d want 0", pc);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_halted: got %b want 0", halted);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_r [0:5];
    int n;
    exp_r = '{32'd0, 32'd10, 32'd20,
              32'd25, 32'd30, 32'd55};
    enter_reset();
    plen = 9;
    prog[0] = 32'h2801000a;
    prog[1] = 32'h28020014;
    prog[2] = 32'h28030019;
    prog[3] = 32'h0ce77800;
    prog[4] = 32'h0ce77800;
    prog[5] = 32'h00222000;
    prog[6] = 32'h0ce77800;
    prog[7] = 32'h00832800;
    prog[8] = 32'hfc000000;
    load_prog();
    release_reset();
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 4) begin
        checks++;
        if (dut.Reg[1] !== 32'd1) begin
          errors++;
          $display("FAIL basic_wb_early: R1=%0d want 1",
                   dut.Reg[1]);
        end
      end
      if (n == 5) begin
        checks++;
        if (dut.Reg[1] !== 32'd10) begin
          errors++;
          $display("FAIL basic_wb_lat: R1=%0d want 10",
                   dut.Reg[1]);
        end
      end
    end
    checks++;
    if (halted !== 1'b1 || n != 13) begin
      errors++;
      $display("FAIL basic_halt: halted=%b cyc=%0d want 1/13",
               halted, n);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (dut.Reg[k] !== exp_r[k]) begin
        errors++;
        $display("FAIL basic_r%0d: got %0d want %0d",
                 k, dut.Reg[k], exp_r[k]);
      end
    end
    checks++;
    if (dut.Reg[15] !== 32'd7) begin
      errors++;
      $display("FAIL basic_r15: got %0d want 7", dut.Reg[15]);
    end
    checks++;
    if (pc !== 32'd9) begin
      errors++;
      $display("FAIL basic_pc: got %0d want 9", pc);
    end
  endtask

  task automatic test_forwarding();
    int n;
    enter_reset();
    plen = 6;
    prog[0] = 32'h2801000a;
    prog[1] = 32'h28020014;
    prog[2] = 32'h28030019;
    prog[3] = 32'h00222000;
    prog[4] = 32'h00832800;
    prog[5] = 32'hfc000000;
    load_prog();
    release_reset();
    wait_halt(40, n);
    checks++;
    if (halted !== 1'b1 || n != 10) begin
      errors++;
      $display("FAIL fwd_halt: halted=%b cyc=%0d want 1/10",
               halted, n);
    end
    checks++;
    if (dut.Reg[4] !== 32'd30) begin
      errors++;
      $display("FAIL fwd_r4: got %0d want 30", dut.Reg[4]);
    end
    checks++;
    if (dut.Reg[5] !== 32'd55) begin
      errors++;
      $display("FAIL fwd_r5: got %0d want 55", dut.Reg[5]);
    end
  endtask

  task automatic test_load_use();
    int n;
    enter_reset();
    plen = 5;
    prog[0] = 32'h28010078;
    prog[1] = 32'h20220000;
    prog[2] = 32'h2842002d;
    prog[3] = 32'h24220001;
    prog[4] = 32'hfc000000;
    load_prog();
    dut.Mem[120] = 32'd85;
    release_reset();
    wait_halt(40, n);
    checks++;
    if (halted !== 1'b1 || n != 10) begin
      errors++;
      $display("FAIL lu_halt: halted=%b cyc=%0d want 1/10",
               halted, n);
    end
    checks++;
    if (dut.Mem[121] !== 32'd130) begin
      errors++;
      $display("FAIL lu_mem121: got %0d want 130",
               dut.Mem[121]);
    end
    checks++;
    if (dut.Reg[2] !== 32'd130) begin
      errors++;
      $display("FAIL lu_r2: got %0d want 130", dut.Reg[2]);
    end
  endtask

  task automatic test_branch_loop();
    int n;
    enter_reset();
    load_fact();
    release_reset();
    wait_halt(300, n);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL br_halt: halted=%b want 1 after %0d",
               halted, n);
    end
    checks++;
    if (dut.Mem[198] !== 32'd5040) begin
      errors++;
      $display("FAIL br_fact: got %0d want 5040",
               dut.Mem[198]);
    end
    checks++;
    if (dut.Reg[9] !== 32'd9) begin
      errors++;
      $display("FAIL br_squash_r9: got %0d want 9",
               dut.Reg[9]);
    end
    checks++;
    if (dut.Reg[3] !== 32'd0) begin
      errors++;
      $display("FAIL br_r3: got %0d want 0", dut.Reg[3]);
    end
  endtask

  task automatic test_halt_freeze();
    int n;
    int drops;
    enter_reset();
    plen = 3;
    prog[0] = 32'h28000005;
    prog[1] = 32'hfc000000;
    prog[2] = 32'h28060063;
    load_prog();
    release_reset();
    wait_halt(40, n);
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (halted !== 1'b1)
        drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL hlt_hold: halted low %0d cycles want 0",
               drops);
    end
    checks++;
    if (pc !== 32'd2) begin
      errors++;
      $display("FAIL hlt_pc: got %0d want 2", pc);
    end
    checks++;
    if (dut.Reg[0] !== 32'd0) begin
      errors++;
      $display("FAIL hlt_r0: got %0d want 0", dut.Reg[0]);
    end
    checks++;
    if (dut.Reg[6] !== 32'd6) begin
      errors++;
      $display("FAIL hlt_r6: got %0d want 6", dut.Reg[6]);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    enter_reset();
    load_fact();
    release_reset();
    repeat (25) @(negedge clk);
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_running: halted=%b want 0", halted);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL mid_pc: got %0d want 0", pc);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_halted: got %b want 0", halted);
    end
    dut.Mem[198] = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut.Mem[198] !== 32'd0) begin
      errors++;
      $display("FAIL mid_nowrite: got %0d want 0",
               dut.Mem[198]);
    end
    release_reset();
    wait_halt(300, n);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL mid_rerun_halt: halted=%b want 1",
               halted);
    end
    checks++;
    if (dut.Mem[198] !== 32'd5040) begin
      errors++;
      $display("FAIL mid_rerun_fact: got %0d want 5040",
               dut.Mem[198]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forwarding();
    test_load_use();
    test_branch_loop();
    test_halt_freeze();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
